// File: rtl/boolexp_lut_if.sv
// Bundles the evaluation, configuration and sweep signals of boolexp_lut.
// The master drives the requests (in_vec/in_valid, cfg_start/cfg_bit,
// sweep_start). The slave (the LUT) returns:
//   - the registered result out_y/out_valid,
//   - the load status cfg_busy/cfg_done,
//   - the sweep status sweep_busy/sweep_done,
//   - the minterm_count.
// N is the number of function inputs (2..6).
interface boolexp_lut_if #(
   parameter int N = 3
);
   logic [N-1:0] in_vec;
   logic         in_valid;
   logic         out_y;
   logic         out_valid;
   logic         cfg_start;
   logic         cfg_bit;
   logic         cfg_busy;
   logic         cfg_done;
   logic         sweep_start;
   logic         sweep_busy;
   logic         sweep_done;
   logic [N:0]   minterm_count;

   modport master (
      output in_vec, in_valid, cfg_start, cfg_bit, sweep_start,
      input  out_y, out_valid, cfg_busy, cfg_done, sweep_busy, sweep_done, minterm_count
   );

   modport slave (
      input  in_vec, in_valid, cfg_start, cfg_bit, sweep_start,
      output out_y, out_valid, cfg_busy, cfg_done, sweep_busy, sweep_done, minterm_count
   );
endinterface

// File: rtl/boolexp_lut.sv
// Reprogrammable N-input boolean function held as a W = 2^N bit truth table.
//
// Ports:
//   clk  - system clock; all state changes on the rising edge.
//   rst  - synchronous, active-high reset. It restores TT_RESET, clears all
//          outputs and aborts any load or sweep that is in progress.
//   bus  - boolexp_lut_if slave modport:
//     in_vec/in_valid     - evaluate tt[in_vec]. The result appears on
//                           out_y/out_valid one cycle later (IDLE only).
//     cfg_start/cfg_bit   - serial table load, W bits, MSB first.
//                           cfg_busy is high during the load; cfg_done
//                           pulses once the new table is active.
//     sweep_start         - counts the ones in the active table.
//                           sweep_busy is high during the count; sweep_done
//                           pulses once minterm_count holds the result.
module boolexp_lut #(
   parameter int                 N        = 3,
   parameter logic [(1<<N)-1:0]  TT_RESET = 8'hE1
) (
   input  logic           clk,
   input  logic           rst,
   boolexp_lut_if.slave   bus
);
   localparam int W = 1 << N;
   localparam logic [N-1:0] LAST = {N{1'b1}};   // W-1

   typedef enum logic [1:0] {IDLE, LOAD, SWEEP} state_t;

   state_t         state_reg;
   logic [W-1:0]   tt_reg;
   logic [W-1:0]   shadow_reg;
   logic [N-1:0]   bit_cnt_reg;
   logic [N-1:0]   idx_cnt_reg;
   logic [N:0]     acc_reg;
   logic           y_reg;
   logic           valid_reg;
   logic           cfg_busy_reg;
   logic           cfg_done_reg;
   logic           sweep_busy_reg;
   logic           sweep_done_reg;
   logic [N:0]     count_reg;

   // Shadow contents including the bit arriving this cycle. Committing this
   // value on the final bit lets the new table be active in the very next
   // cycle.
   logic [W-1:0]   shadow_next;
   // The swept table bit, zero-extended to the accumulator width.
   logic [N:0]     tt_bit_ext;

   assign shadow_next = {shadow_reg[W-2:0], bus.cfg_bit};
   assign tt_bit_ext  = {{N{1'b0}}, tt_reg[idx_cnt_reg]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         tt_reg         <= TT_RESET;
         shadow_reg     <= '0;
         bit_cnt_reg    <= '0;
         idx_cnt_reg    <= '0;
         acc_reg        <= '0;
         y_reg          <= 1'b0;
         valid_reg      <= 1'b0;
         cfg_busy_reg   <= 1'b0;
         cfg_done_reg   <= 1'b0;
         sweep_busy_reg <= 1'b0;
         sweep_done_reg <= 1'b0;
         count_reg      <= '0;
      end else begin
         // The valid flag and the done flags are single-cycle pulses by
         // default.
         valid_reg      <= 1'b0;
         cfg_done_reg   <= 1'b0;
         sweep_done_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (bus.in_valid) begin
                  y_reg     <= tt_reg[bus.in_vec];
                  valid_reg <= 1'b1;
               end
               // A load has priority; a sweep_start in the same cycle is
               // dropped.
               if (bus.cfg_start) begin
                  state_reg    <= LOAD;
                  cfg_busy_reg <= 1'b1;
                  bit_cnt_reg  <= '0;
               end else if (bus.sweep_start) begin
                  state_reg      <= SWEEP;
                  sweep_busy_reg <= 1'b1;
                  idx_cnt_reg    <= '0;
                  acc_reg        <= '0;
               end
            end

            LOAD: begin
               shadow_reg <= shadow_next;
               if (bit_cnt_reg == LAST) begin
                  tt_reg       <= shadow_next;
                  state_reg    <= IDLE;
                  cfg_busy_reg <= 1'b0;
                  cfg_done_reg <= 1'b1;
                  bit_cnt_reg  <= '0;
               end else begin
                  bit_cnt_reg <= bit_cnt_reg + 1'b1;
               end
            end

            SWEEP: begin
               if (idx_cnt_reg == LAST) begin
                  count_reg      <= acc_reg + tt_bit_ext;
                  state_reg      <= IDLE;
                  sweep_busy_reg <= 1'b0;
                  sweep_done_reg <= 1'b1;
                  idx_cnt_reg    <= '0;
               end else begin
                  acc_reg     <= acc_reg + tt_bit_ext;
                  idx_cnt_reg <= idx_cnt_reg + 1'b1;
               end
            end

            default: begin
               state_reg      <= IDLE;
               cfg_busy_reg   <= 1'b0;
               sweep_busy_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out_y         = y_reg;
   assign bus.out_valid     = valid_reg;
   assign bus.cfg_busy      = cfg_busy_reg;
   assign bus.cfg_done      = cfg_done_reg;
   assign bus.sweep_busy    = sweep_busy_reg;
   assign bus.sweep_done    = sweep_done_reg;
   assign bus.minterm_count = count_reg;
endmodule

// File: tb/tb_boolexp_lut.sv
// Directed bench for boolexp_lut with N=3 and TT_RESET=8'hE1.
// Each evaluation pushes its hand-derived result into a scoreboard queue.
// A monitor pops and compares the queue whenever out_valid is seen.
module tb_boolexp_lut;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   boolexp_lut_if #(.N(3)) bus ();

   boolexp_lut #(.N(3), .TT_RESET(8'hE1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [2:0] vec;
      logic       y;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  tt_m;   // table the DUT should hold
   logic        y_m;    // value out_y should be holding
   logic [3:0]  mc_m;   // value minterm_count should be holding
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: every out_valid must match the oldest outstanding evaluation.
   always @(negedge clk) begin
      if (bus.out_valid) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_out_valid at %0t: got out_valid=1, expected 0", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (bus.out_y !== e.y) begin
               n_fail++;
               $display("FAIL eval_out_y in_vec=%0d at %0t: got %0b, expected %0b",
                        e.vec, $time, bus.out_y, e.y);
            end else begin
               $display("txn eval in_vec=%0d out_y=%0b", e.vec, bus.out_y);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic eval(input logic [2:0] v);
      bus.in_vec   = v;
      bus.in_valid = 1'b1;
      sb.push_back('{v, tt_m[v]});
      y_m = tt_m[v];
      tick();
      bus.in_valid = 1'b0;
   endtask

   // Serial load of 'bits', MSB first.
   //   both   - also raise sweep_start in the start cycle.
   //   sw_mid - raise sweep_start partway through the load.
   //   iv_mid - present in_valid on every load cycle, each time with a
   //            vector whose table bit differs from the held out_y.
   task automatic do_load(input logic [7:0] bits, input bit both, input bit sw_mid, input bit iv_mid);
      logic [2:0] vsel;
      vsel = '0;
      for (int j = 0; j < 8; j++)
         if (tt_m[j] != y_m) vsel = 3'(j);
      bus.cfg_start   = 1'b1;
      bus.sweep_start = both;
      chk("cfg_busy_before_load", {31'b0, bus.cfg_busy}, 0);
      tick();
      bus.cfg_start   = 1'b0;
      bus.sweep_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.cfg_bit     = bits[7-i];
         bus.sweep_start = sw_mid && (i == 3);
         if (iv_mid) begin
            bus.in_valid = 1'b1;
            bus.in_vec   = vsel;
         end
         chk("cfg_busy_during_load", {31'b0, bus.cfg_busy}, 1);
         chk("cfg_done_during_load", {31'b0, bus.cfg_done}, 0);
         chk("sweep_busy_during_load", {31'b0, bus.sweep_busy}, 0);
         chk("out_y_held_during_load", {31'b0, bus.out_y}, {31'b0, y_m});
         tick();
      end
      bus.sweep_start = 1'b0;
      bus.in_valid    = 1'b0;
      tt_m = bits;
      chk("cfg_busy_after_load", {31'b0, bus.cfg_busy}, 0);
      chk("cfg_done_pulse", {31'b0, bus.cfg_done}, 1);
      chk("sweep_busy_after_load", {31'b0, bus.sweep_busy}, 0);
      chk("out_y_held_after_load", {31'b0, bus.out_y}, {31'b0, y_m});
      $display("txn load tt=%02h", bits);
   endtask

   task automatic do_sweep(input logic [3:0] expc);
      bus.sweep_start = 1'b1;
      tick();
      bus.sweep_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("sweep_busy_during_sweep", {31'b0, bus.sweep_busy}, 1);
         chk("sweep_done_during_sweep", {31'b0, bus.sweep_done}, 0);
         chk("minterm_count_held", {28'b0, bus.minterm_count}, {28'b0, mc_m});
         tick();
      end
      mc_m = expc;
      chk("sweep_busy_after_sweep", {31'b0, bus.sweep_busy}, 0);
      chk("sweep_done_pulse", {31'b0, bus.sweep_done}, 1);
      chk("minterm_count", {28'b0, bus.minterm_count}, {28'b0, expc});
      $display("txn sweep minterm_count=%0d", bus.minterm_count);
      tick();
      chk("sweep_done_one_cycle", {31'b0, bus.sweep_done}, 0);
      chk("minterm_count_hold", {28'b0, bus.minterm_count}, {28'b0, expc});
   endtask

   initial begin
      bus.in_vec      = '0;
      bus.in_valid    = 1'b0;
      bus.cfg_start   = 1'b0;
      bus.cfg_bit     = 1'b0;
      bus.sweep_start = 1'b0;
      tt_m = 8'hE1;
      y_m  = 1'b0;
      mc_m = 4'd0;

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
      chk("rst_out_y", {31'b0, bus.out_y}, 0);
      chk("rst_cfg_busy", {31'b0, bus.cfg_busy}, 0);
      chk("rst_cfg_done", {31'b0, bus.cfg_done}, 0);
      chk("rst_sweep_busy", {31'b0, bus.sweep_busy}, 0);
      chk("rst_sweep_done", {31'b0, bus.sweep_done}, 0);
      chk("rst_minterm_count", {28'b0, bus.minterm_count}, 0);

      // Reset table E1: expected results 1,0,0,0,0,1,1,1
      for (int v = 0; v < 8; v++) eval(3'(v));
      tick();
      tick();
      chk("idle_out_valid_low", {31'b0, bus.out_valid}, 0);
      chk("idle_out_y_held", {31'b0, bus.out_y}, {31'b0, y_m});

      // Reset table has 4 ones
      do_sweep(4'd4);

      // Load 8'h69 while in_valid is presented, then evaluate immediately
      do_load(8'h69, 1'b0, 1'b0, 1'b1);
      eval(3'd3);   // 8'h69 bit 3 = 1
      eval(3'd1);   // 8'h69 bit 1 = 0
      chk("cfg_done_one_cycle", {31'b0, bus.cfg_done}, 0);
      tick();
      do_sweep(4'd4);

      // All-ones table counts to 8 without overflow
      do_load(8'hFF, 1'b0, 1'b0, 1'b0);
      tick();
      do_sweep(4'd8);

      // Simultaneous start and mid-load sweep_start: only the load runs
      do_load(8'h0F, 1'b1, 1'b1, 1'b0);
      tick();
      chk("sweep_not_queued", {31'b0, bus.sweep_busy}, 0);
      chk("minterm_after_dropped_sweep", {28'b0, bus.minterm_count}, 4'd8);
      eval(3'd4);   // 8'h0F bit 4 = 0
      eval(3'd2);   // 8'h0F bit 2 = 1
      tick();
      do_sweep(4'd4);

      // Reset during the 4th load bit of an all-zero table
      bus.cfg_start = 1'b1;
      tick();
      bus.cfg_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.cfg_bit = 1'b0;
         tick();
      end
      rst = 1'b1;
      bus.cfg_bit = 1'b0;
      tick();
      rst = 1'b0;
      tt_m = 8'hE1;
      y_m  = 1'b0;
      mc_m = 4'd0;
      chk("abort_cfg_busy", {31'b0, bus.cfg_busy}, 0);
      chk("abort_cfg_done", {31'b0, bus.cfg_done}, 0);
      chk("abort_minterm_count", {28'b0, bus.minterm_count}, 0);
      chk("abort_out_y", {31'b0, bus.out_y}, 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("abort_no_cfg_done", {31'b0, bus.cfg_done}, 0);
         chk("abort_no_cfg_busy", {31'b0, bus.cfg_busy}, 0);
      end
      eval(3'd0);   // E1 retained: 1
      eval(3'd4);   // E1 bit 4 = 0
      tick();
      tick();

      chk("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/boolexp_lut.md
BOOLEXP_LUT -- requirements
Module: boolexp_lut

Interface
REQ-001 SHALL provide parameter N, default 3, number of function inputs (legal range 2..6).
REQ-002 SHALL provide parameter TT_RESET, default 8'hE1 (width 2^N), truth table loaded at reset; bit i = output for input vector value i.
REQ-003 SHALL provide ports (clock and reset first):
  clk  input  1  system clock, all state on rising edge
  rst  input  1  synchronous, active-high reset
  in_vec  input  N  input vector to evaluate
  in_valid  input  1  in_vec valid this cycle
  out_y  output  1  registered function result
  out_valid  output  1  out_y updated this cycle
  cfg_start  input  1  begin serial truth-table load
  cfg_bit  input  1  serial truth-table data, MSB-first
  cfg_busy  output  1  load in progress
  cfg_done  output  1  one-cycle pulse, new table active
  sweep_start  input  1  begin minterm count of active table
  sweep_busy  output  1  sweep in progress
  sweep_done  output  1  one-cycle pulse, count valid
  minterm_count  output  N+1  number of 1 bits in active table
REQ-004 SHALL use one clock and a synchronous, active-high reset only; no other clocks or asynchronous logic.

Function
REQ-005 SHALL implement a registered FSM with states IDLE, LOAD and SWEEP; W = 2^N.
REQ-006 In IDLE with in_valid=1 in cycle k, SHALL drive out_y = tt[in_vec] and out_valid=1 in cycle k+1 (latency 1).
REQ-007 With in_valid=0, SHALL hold out_y and drive out_valid=0 the next cycle.
REQ-008 In LOAD or SWEEP, SHALL ignore in_valid: out_valid=0, out_y held.
REQ-009 IDLE with cfg_start=1 in cycle s SHALL enter LOAD; cfg_busy=1 in cycles s+1..s+W; cfg_bit sampled in each of those cycles into a shadow register, first bit -> tt[W-1], last bit -> tt[0].
REQ-010 At end of cycle s+W, SHALL copy shadow to tt and return to IDLE; cfg_done=1 in cycle s+W+1 only; in_valid in cycle s+W+1 evaluates against the new table.
REQ-011 During LOAD, the active tt SHALL remain unchanged; evaluation is blocked only by REQ-008.
REQ-012 IDLE with sweep_start=1 in cycle s SHALL enter SWEEP; sweep_busy=1 in cycles s+1..s+W; an index counter steps 0..W-1, accumulating tt[index].
REQ-013 SHALL load the final sum into minterm_count at end of cycle s+W; sweep_done=1 in cycle s+W+1 only; minterm_count holds until the next sweep completes or reset.
REQ-014 minterm_count SHALL be N+1 bits wide so W ones (all-ones table) is representable without overflow.
REQ-015 Simultaneous cfg_start and sweep_start in IDLE: SHALL enter LOAD; the sweep_start is dropped.
REQ-016 cfg_start or sweep_start while not IDLE SHALL be ignored and not queued.
REQ-017 Index and bit counters SHALL terminate at W-1 and never wrap into a second pass.

Reset
REQ-018 rst=1 at any edge SHALL set state IDLE, tt=TT_RESET, shadow=0, counters=0, out_y=0, out_valid=0, cfg_done=0, sweep_done=0, minterm_count=0, cfg_busy=0, sweep_busy=0.
REQ-019 Reset during LOAD or SWEEP SHALL abort the operation with no partial table update and no done pulse.

Verification (N=3, TT_RESET=8'hE1)
REQ-020 After reset, in_vec 0..7 back-to-back with in_valid=1 -> out_y 1,0,0,0,0,1,1,1 one cycle later each, out_valid=1 throughout.
REQ-021 cfg_start at cycle s, cfg_bit 0,1,1,0,1,0,0,1 (8'h69) -> cfg_busy high s+1..s+8, cfg_done at s+9; in_vec=3 -> out_y=1, in_vec=1 -> out_y=0.
REQ-022 sweep_start after reset -> sweep_busy for 8 cycles, sweep_done at s+9, minterm_count=4; after loading 8'hFF and sweeping -> minterm_count=8.
REQ-023 rst asserted during 4th load bit -> cfg_busy=0 next cycle, no cfg_done; in_vec=0 -> out_y=1 (8'hE1 retained).
REQ-024 cfg_start and sweep_start in the same cycle -> only LOAD runs, sweep_busy stays 0; sweep_start during LOAD -> ignored, minterm_count unchanged.
REQ-025 in_valid=1 during LOAD -> out_valid=0 and out_y unchanged until return to IDLE.
